// File: rtl/active_list.sv
// In-order retirement buffer: allocates at dispatch, marks entries done on
// out-of-order completion, and retires one done entry per cycle from the head.
module active_list #(
  parameter int ADDR_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [FREE_LIST_WIDTH-1:0] alloc_index,
  input  logic [ADDR_WIDTH-1:0]      alloc_pc,
  input  logic                       alloc_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_virtual_addr,
  input  logic [REG_ADDR_WIDTH:0]    alloc_physical_addr,
  input  logic [REG_ADDR_WIDTH:0]    alloc_old_physical_addr,
  input  logic                       complete_valid,
  input  logic [FREE_LIST_WIDTH-1:0] complete_index,
  output logic                       commit_valid,
  output logic [FREE_LIST_WIDTH-1:0] commit_index,
  output logic [ADDR_WIDTH-1:0]      commit_pc,
  output logic                       commit_wb_reg,
  output logic [REG_ADDR_WIDTH-1:0]  commit_virtual_addr,
  output logic [REG_ADDR_WIDTH:0]    commit_physical_addr,
  output logic [REG_ADDR_WIDTH:0]    commit_free_addr,
  output logic [FREE_LIST_WIDTH:0]   count,
  output logic                       empty,
  output logic                       full
);

  localparam int DEPTH = 1 << FREE_LIST_WIDTH;
  localparam logic [FREE_LIST_WIDTH:0] DEPTH_CNT = (FREE_LIST_WIDTH+1)'(DEPTH);

  logic [FREE_LIST_WIDTH-1:0] head_q, tail_q;
  logic [FREE_LIST_WIDTH:0]   count_q;
  logic [DEPTH-1:0]           valid_q, done_q;

  logic [ADDR_WIDTH-1:0]     pc_mem     [DEPTH];
  logic                      wb_mem     [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] vaddr_mem  [DEPTH];
  logic [REG_ADDR_WIDTH:0]   paddr_mem  [DEPTH];
  logic [REG_ADDR_WIDTH:0]   old_pa_mem [DEPTH];

  logic alloc_fire, commit_fire, complete_fire;

  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_index = tail_q;
  assign count       = count_q;

  // Readiness is judged on the registered count only; a same-cycle retire
  // never frees a slot for a same-cycle allocation.
  assign alloc_fire    = alloc_valid && !full && !flush;
  assign commit_fire   = valid_q[head_q] && done_q[head_q] && !flush;
  assign complete_fire = complete_valid && valid_q[complete_index] && !flush;

  // NOTE: payload storage carries no reset; valid_q gates every use of it,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_mem[tail_q]     <= alloc_pc;
      wb_mem[tail_q]     <= alloc_wb_reg;
      vaddr_mem[tail_q]  <= alloc_virtual_addr;
      paddr_mem[tail_q]  <= alloc_physical_addr;
      old_pa_mem[tail_q] <= alloc_old_physical_addr;
    end
  end

  // NOTE: state uses non-blocking assignments; later writes to the same bit
  // in this block win, so the order complete -> commit -> alloc is deliberate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      valid_q              <= '0;
      done_q               <= '0;
      commit_valid         <= 1'b0;
      commit_index         <= '0;
      commit_pc            <= '0;
      commit_wb_reg        <= 1'b0;
      commit_virtual_addr  <= '0;
      commit_physical_addr <= '0;
      commit_free_addr     <= '0;
    end else if (flush) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      done_q       <= '0;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= commit_fire;
      if (complete_fire) done_q[complete_index] <= 1'b1;
      if (commit_fire) begin
        valid_q[head_q]      <= 1'b0;
        done_q[head_q]       <= 1'b0;
        head_q               <= head_q + 1'b1;
        commit_index         <= head_q;
        commit_pc            <= pc_mem[head_q];
        commit_wb_reg        <= wb_mem[head_q];
        commit_virtual_addr  <= vaddr_mem[head_q];
        commit_physical_addr <= paddr_mem[head_q];
        commit_free_addr     <= old_pa_mem[head_q];
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_q + (FREE_LIST_WIDTH+1)'(alloc_fire)
                         - (FREE_LIST_WIDTH+1)'(commit_fire);
    end
  end

endmodule

// File: tb/tb_active_list.sv
// Directed bench for active_list: stimulus pushes expected retirements into
// a queue, a negedge monitor pops and compares every commit pulse.
module tb_active_list;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [2:0]  alloc_index;
  logic [31:0] alloc_pc;
  logic        alloc_wb_reg;
  logic [4:0]  alloc_virtual_addr;
  logic [5:0]  alloc_physical_addr;
  logic [5:0]  alloc_old_physical_addr;
  logic        complete_valid;
  logic [2:0]  complete_index;
  logic        commit_valid;
  logic [2:0]  commit_index;
  logic [31:0] commit_pc;
  logic        commit_wb_reg;
  logic [4:0]  commit_virtual_addr;
  logic [5:0]  commit_physical_addr;
  logic [5:0]  commit_free_addr;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  active_list dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .alloc_pc(alloc_pc), .alloc_wb_reg(alloc_wb_reg),
    .alloc_virtual_addr(alloc_virtual_addr), .alloc_physical_addr(alloc_physical_addr),
    .alloc_old_physical_addr(alloc_old_physical_addr),
    .complete_valid(complete_valid), .complete_index(complete_index),
    .commit_valid(commit_valid), .commit_index(commit_index), .commit_pc(commit_pc),
    .commit_wb_reg(commit_wb_reg), .commit_virtual_addr(commit_virtual_addr),
    .commit_physical_addr(commit_physical_addr), .commit_free_addr(commit_free_addr),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] pc;
    logic        wb;
    logic [4:0]  va;
    logic [5:0]  pa;
    logic [5:0]  fa;
  } commit_t;

  commit_t    exp_q[$];
  logic [2:0] exp_tail;
  int         serial;
  int         n_checks;
  int         n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, then returns #1 after the rising edge.
  task automatic tick(input bit a_v, input logic [5:0] old_pa, input bit accept,
                      input bit c_v, input logic [2:0] c_idx, input bit fl);
    commit_t e;
    alloc_valid             = a_v;
    alloc_pc                = 32'h1000 + 32'(serial * 4);
    alloc_wb_reg            = serial[0];
    alloc_virtual_addr      = serial[4:0];
    alloc_physical_addr     = {1'b1, serial[4:0]};
    alloc_old_physical_addr = old_pa;
    complete_valid          = c_v;
    complete_index          = c_idx;
    flush                   = fl;
    if (a_v && accept) begin
      e = '{idx: exp_tail, pc: alloc_pc, wb: alloc_wb_reg, va: alloc_virtual_addr,
            pa: alloc_physical_addr, fa: old_pa};
      exp_q.push_back(e);
      exp_tail = exp_tail + 3'd1;
    end
    if (a_v) serial++;
    @(posedge clk);
    #1;
    alloc_valid    = 1'b0;
    complete_valid = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 6'h0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic alloc(input logic [5:0] old_pa);
    check("alloc_index", 64'(alloc_index), 64'(exp_tail));
    tick(1'b1, old_pa, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic complete(input logic [2:0] idx);
    tick(1'b0, 6'h0, 1'b0, 1'b1, idx, 1'b0);
  endtask

  // Scoreboard monitor: every commit pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && commit_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 64'(commit_index), 64'hFFFF);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        check("commit_fields",
              64'({commit_index, commit_pc, commit_wb_reg, commit_virtual_addr,
                   commit_physical_addr, commit_free_addr}),
              64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; serial = 0; exp_tail = 3'd0;
    rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; complete_valid = 1'b0;
    complete_index = 3'd0; alloc_pc = '0; alloc_wb_reg = 1'b0;
    alloc_virtual_addr = '0; alloc_physical_addr = '0; alloc_old_physical_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ready", 64'(alloc_ready), 64'd1);
    check("rst_index", 64'(alloc_index), 64'd0);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_free_addr", 64'(commit_free_addr), 64'd0);
    rst_n = 1'b1;

    // Fill to full, then a refused 9th request.
    for (int k = 0; k < 8; k++) alloc(6'(8'h10 + k));
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(alloc_ready), 64'd0);
    check("fill_count", 64'(count), 64'd8);
    tick(1'b1, 6'h3f, 1'b0, 1'b0, 3'd0, 1'b0);
    check("ninth_count", 64'(count), 64'd8);
    check("ninth_index", 64'(alloc_index), 64'd0);

    // Complete all 8 in order: back-to-back retirement.
    for (int k = 0; k < 8; k++) begin
      complete(3'(k));
      check("drain_commit_valid", 64'(commit_valid), 64'(k != 0));
    end
    idle();
    check("drain_last_commit", 64'(commit_valid), 64'd1);
    check("drain_last_index", 64'(commit_index), 64'd7);
    idle();
    check("drain_idle_commit", 64'(commit_valid), 64'd0);
    check("drain_count", 64'(count), 64'd0);
    check("drain_empty", 64'(empty), 64'd1);

    // Wrapped allocation plus out-of-order completion 2,1,0.
    alloc(6'h21); alloc(6'h22); alloc(6'h23);
    complete(3'd2); check("ooo_c2", 64'(commit_valid), 64'd0);
    complete(3'd1); check("ooo_c1", 64'(commit_valid), 64'd0);
    complete(3'd0); check("ooo_c0", 64'(commit_valid), 64'd0);
    idle(); check("ooo_r0", 64'(commit_free_addr), 64'h21);
    idle(); check("ooo_r1", 64'(commit_free_addr), 64'h22);
    idle(); check("ooo_r2", 64'(commit_free_addr), 64'h23);
    check("ooo_r2_valid", 64'(commit_valid), 64'd1);
    idle(); check("ooo_stop", 64'(commit_valid), 64'd0);
    check("ooo_count", 64'(count), 64'd0);

    // Simultaneous alloc and commit at count 4 (entries 3..6).
    for (int k = 0; k < 4; k++) alloc(6'(8'h30 + k));
    complete(3'd3);
    check("sim_count_pre", 64'(count), 64'd4);
    alloc(6'h34);
    check("sim_count", 64'(count), 64'd4);
    check("sim_commit_index", 64'(commit_index), 64'd3);
    for (int k = 0; k < 4; k++) alloc(6'(8'h35 + k));
    check("sim_full", 64'(full), 64'd1);
    complete(3'd4);
    check("full_done_count", 64'(count), 64'd8);
    tick(1'b1, 6'h3e, 1'b0, 1'b0, 3'd0, 1'b0);
    check("full_refuse_count", 64'(count), 64'd7);
    check("full_refuse_index", 64'(alloc_index), 64'd4);
    check("full_refuse_commit", 64'(commit_valid), 64'd1);
    complete(3'd5); complete(3'd6); complete(3'd7); complete(3'd0);
    complete(3'd1); complete(3'd2); complete(3'd3);
    idle(); idle();
    check("sim_drain_count", 64'(count), 64'd0);
    check("sim_drain_commit", 64'(commit_valid), 64'd0);

    // Flush with the head ready to retire on the flush edge.
    for (int k = 0; k < 5; k++) alloc(6'(8'h01 + k));
    complete(3'd5);
    complete(3'd4);
    check("pre_flush_commit", 64'(commit_valid), 64'd0);
    exp_q.delete();
    exp_tail = 3'd0;
    tick(1'b1, 6'h3d, 1'b0, 1'b1, 3'd6, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_commit", 64'(commit_valid), 64'd0);
    check("flush_index", 64'(alloc_index), 64'd0);
    idle();
    check("post_flush_commit", 64'(commit_valid), 64'd0);

    // Spurious completion of invalid entry 5 must not stick.
    complete(3'd5);
    check("spur_count", 64'(count), 64'd0);
    check("spur_commit", 64'(commit_valid), 64'd0);
    for (int k = 0; k < 6; k++) alloc(6'(8'h11 + k));
    for (int k = 0; k < 5; k++) complete(3'(k));
    idle(); idle(); idle();
    check("spur_hold_count", 64'(count), 64'd1);
    check("spur_hold_commit", 64'(commit_valid), 64'd0);
    complete(3'd5);
    check("spur_c5", 64'(commit_valid), 64'd0);
    idle();
    check("spur_r5", 64'(commit_index), 64'd5);
    check("spur_empty", 64'(count), 64'd0);

    // Asynchronous reset in the middle of a cycle.
    alloc(6'h2a); alloc(6'h2b);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_tail = 3'd0;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_ready", 64'(alloc_ready), 64'd1);
    check("mid_rst_index", 64'(alloc_index), 64'd0);
    check("mid_rst_commit", 64'(commit_valid), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    alloc(6'h2c);
    complete(3'd0);
    idle();
    check("post_rst_commit", 64'(commit_free_addr), 64'h2c);
    idle();
    check("leftover_expect", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/active_list.md
# active_list

In-order retirement buffer (active list) for the renamed pipeline. Instructions are allocated at dispatch in program order, each tagged with an active-list index. Completions arrive out of order from the write-back end of the EX/MEM/WB path, keyed by that index. Entries retire strictly in order from the head, releasing the superseded physical register back to the free list.

## Interface
- ADDR_WIDTH, 32, PC width
- REG_ADDR_WIDTH, 5, architectural register address width; physical addresses are REG_ADDR_WIDTH+1 bits
- FREE_LIST_WIDTH, 3, index width; DEPTH = 2^FREE_LIST_WIDTH entries

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (mispredict/exception recovery)
- alloc_valid  in  1  dispatch request
- alloc_ready  out  1  = !full; combinational from registered count
- alloc_index  out  FREE_LIST_WIDTH  = tail pointer; tag returned to dispatch
- alloc_pc  in  ADDR_WIDTH  PC of the dispatched instruction
- alloc_wb_reg  in  1  instruction writes a register
- alloc_virtual_addr  in  REG_ADDR_WIDTH  architectural destination
- alloc_physical_addr  in  REG_ADDR_WIDTH+1  new physical destination
- alloc_old_physical_addr  in  REG_ADDR_WIDTH+1  previous mapping, freed at commit
- complete_valid  in  1  completion strobe from write-back
- complete_index  in  FREE_LIST_WIDTH  entry that completed
- commit_valid  out  1  registered one-cycle retire pulse
- commit_index, commit_pc, commit_wb_reg, commit_virtual_addr, commit_physical_addr, commit_free_addr  out  (widths as the alloc fields)  registered fields of the retired entry
- count  out  FREE_LIST_WIDTH+1  occupied entries
- empty, full  out  1  count==0, count==DEPTH

## Operation
- Storage per entry: valid, done, pc, wb_reg, virtual_addr, physical_addr, old_physical_addr. head, tail, and count are registers.
- Allocate: an allocation fires when alloc_valid && alloc_ready.
  - Writes the entry at tail with valid=1 and done=0.
  - Increments tail mod DEPTH.
  - alloc_valid while full is ignored, and no state changes.
- Complete: when complete_valid is high and entry[complete_index].valid, set done=1.
  - Completion to an invalid entry is ignored.
  - Completion to an entry that is already done is a no-op.
- Commit: fires when entry[head].valid && entry[head].done (registered bits).
  - Clears valid and increments head mod DEPTH.
  - Registers the entry's fields onto the commit_* outputs with commit_valid=1.
  - commit_free_addr = old_physical_addr.
  - The free list and retirement map consume the commit_* outputs only when commit_valid && commit_wb_reg.
  - At most one commit per cycle. There is no backpressure.
  - When no commit fires, commit_valid=0 and the other commit_* outputs hold their last values.
- count update: count += alloc_fire − commit_fire. A simultaneous alloc and commit leaves count unchanged.
- Flush has the highest priority:
  - All valid and done bits clear; head=tail=count=0.
  - commit_valid=0 on that edge.
  - Allocation and completion in the same cycle are dropped.
- Full: alloc_ready does not look ahead to a same-cycle commit. A full list refuses allocation even when the head retires that cycle.
- Wrap-around: indices wrap modulo DEPTH. full and empty are decided by count, never by pointer equality.

## Timing
- Reset (asynchronous, immediate):
  - head, tail, and count are 0, and all valid and done bits are 0.
  - commit_valid=0 and all commit_* fields are 0.
  - Therefore count=0, empty=1, full=0, alloc_ready=1, alloc_index=0.
- Allocation latency: an alloc at edge N makes the entry visible, and alloc_index advances, after N.
- Completion to commit: complete sampled at edge E sets done. The commit fires at edge E+1, and commit_valid is high during cycle E+1..E+2.
  - Minimum alloc→commit is 2 edges after the allocating edge: complete at N+1, commit at N+2.
  - Completion of the entry being allocated in the same cycle is ignored, because that entry is not yet valid.
- Steady state: with all entries done, one retire per cycle, back-to-back.
- Reset deasserted mid-operation: contents are lost; dispatch restarts at index 0.

## Test plan
- Reset: assert rst_n=0 mid-run -> count=0, empty=1, alloc_ready=1, alloc_index=0, commit_valid=0.
- Fill and wrap:
  - Allocate 8 entries -> full=1, alloc_ready=0; a 9th alloc_valid is ignored.
  - Complete all 8 -> 8 consecutive commit_valid pulses with commit_index 0..7.
  - Allocate 3 more -> they take indices 0..2.
- Out-of-order completion:
  - Allocate indices 0,1,2 with old_physical_addr 0x21,0x22,0x23; complete in order 2,1,0.
  - -> no commit until index 0 completes.
  - Then commits 0,1,2 on three consecutive cycles with commit_free_addr 0x21,0x22,0x23.
- Simultaneous alloc and commit:
  - At count=4, alloc and a head commit on the same edge -> count stays 4.
  - At count=8 with the head done, alloc_valid is refused and count becomes 7.
- Flush:
  - Allocate 5 entries and complete 2 of them.
  - Assert flush together with alloc_valid and complete_valid -> count=0, empty=1, no commit_valid on that edge or after, and the next alloc_index=0.
- Spurious completion: complete_index=5 with entry 5 invalid -> no state change. When entry 5 is later allocated it stays done=0 until its own completion arrives.
